// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the generic pipeline stage register.
//   - pipe_state_t : occupancy of a stage (EMPTY / BUSY / FULL)
//   - CTL_W_ID_EX / DATA_W_ID_EX : default widths matching the ID/EX stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Occupancy of a stage register: no entry, main entry only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Control bundle at ID/EX: WB + M + EX bits.
    localparam int CTL_W_ID_EX  = 9;
    // Payload at ID/EX: npc, rdata1, rdata2, sext, rt, rd.
    localparam int DATA_W_ID_EX = 138;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//   One entry of a stage register: a control bundle plus a data payload.
//   The control part can be cleared synchronously (used to kill an entry on
//   flush); the data part only changes on load so that a killed entry's
//   payload stays visible on the data lines.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset, clears ctl and data
//   load    in   capture d_ctl / d_data this cycle
//   clr     in   clear ctl this cycle (wins over load for ctl)
//   d_ctl   in   CTL_W  control bundle to capture
//   d_data  in   DATA_W payload to capture
//   q_ctl   out  CTL_W  held control bundle
//   q_data  out  DATA_W held payload
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int CTL_W  = 9,
    parameter int DATA_W = 138
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr,
    input  logic [CTL_W-1:0]  d_ctl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTL_W-1:0]  q_ctl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_ctl <= '0;
        end else if (clr) begin
            q_ctl <= '0;
        end else if (load) begin
            q_ctl <= d_ctl;
        end
    end

    // Payload ignores clr: a flushed stage keeps showing its last data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_data <= '0;
        end else if (load) begin
            q_data <= d_data;
        end
    end

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register with valid/ready handshake. A main slot
//   drives the outputs; a skid slot catches the one entry that can arrive in
//   the cycle downstream stalls, so in_ready can come straight from a flop
//   instead of combinationally from out_ready. Flush kills everything held
//   and the entry offered that cycle. A saturating counter records cycles in
//   which downstream was ready but this stage had nothing to give.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   upstream entry valid
//   in_ready    out  stage can accept (registered)
//   in_ctl      in   CTL_W  upstream control bundle
//   in_data     in   DATA_W upstream payload
//   flush       in   discard held and incoming entries
//   out_valid   out  downstream entry valid
//   out_ready   in   downstream accepts
//   out_ctl     out  CTL_W  control bundle, zero whenever out_valid=0
//   out_data    out  DATA_W payload, holds last value when out_valid=0
//   bubble_cnt  out  CNT_W  saturating count of out_ready & !out_valid cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTL_W  = CTL_W_ID_EX,
    parameter int DATA_W = DATA_W_ID_EX,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic              rdy_q;

    logic              in_fire;
    logic              out_fire;

    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    logic [CTL_W-1:0]  main_ctl;
    logic [DATA_W-1:0] main_data;
    logic [CTL_W-1:0]  skid_ctl;
    logic [DATA_W-1:0] skid_data;
    logic [CTL_W-1:0]  main_d_ctl;
    logic [DATA_W-1:0] main_d_data;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & rdy_q;
    assign out_fire  = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // Occupancy FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Ready is a function of the state we are about to be in, so it
            // never depends on this cycle's out_ready combinationally.
            rdy_q   <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled: park the new entry behind main.
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists.
                if (out_fire) begin
                    state_d        = BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush beats everything, including an entry accepted this cycle.
        // A same-cycle out_fire already completed downstream and is unaffected.
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    // Main refills from skid when draining FULL, otherwise from upstream;
    // skid is never bypassed so order stays strictly FIFO.
    assign main_d_ctl  = main_from_skid ? skid_ctl  : in_ctl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .CTL_W  (CTL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (load_main),
        .clr    (flush),
        .d_ctl  (main_d_ctl),
        .d_data (main_d_data),
        .q_ctl  (main_ctl),
        .q_data (main_data)
    );

    pipe_slot #(
        .CTL_W  (CTL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (load_skid),
        .clr    (flush),
        .d_ctl  (in_ctl),
        .d_data (in_data),
        .q_ctl  (skid_ctl),
        .q_data (skid_data)
    );

    // Main ctl can still hold a delivered entry after draining to EMPTY, so
    // gate it to keep bubbles as all-zero control downstream.
    assign out_ctl  = out_valid ? main_ctl : '0;
    assign out_data = main_data;

    // -----------------------------------------------------------------------
    // Bubble counter (performance debug, survives flush)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule : pipe_stage_reg
